rank_write_packer: RTL and testbench

Write-back stage downstream of the PageRank core. It accepts a stream of 64-bit rank values and packs them, eight at a time, into 512-bit lines. Each line is written to DRAM through the AXI write channels (AW/W/B) as a single-beat burst, starting at a programmed base address such as write_addr0 or write_addr1. One line is in flight at a time. The block pulses done after the last write response.

---
 rtl/rank_write_packer.sv | 235 +++++++++++++++++++++++
 tb/tb_rank_write_packer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_write_packer.sv
// rank_write_packer
//
// Write-back stage behind the PageRank core. It collects 64-bit rank values
// into 512-bit lines, eight per line, and writes each line to DRAM with one
// single-beat AXI burst. Line 0 goes to base_addr, and each later line goes
// 64 bytes higher. Only one line is in flight at a time. The input stream
// stalls while a line is being written.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start               begin a job (sampled only when idle)
//   base_addr, n_words  job byte address (64-byte aligned) and word count
//   in_valid/in_data    rank value stream, in_ready = accepted this cycle
//   aw*_m               AXI write address channel (id, addr, len, size, valid/ready)
//   w*_m                AXI write data channel (id, data, strb, last, valid/ready)
//   b*_m                AXI write response channel (id, resp, valid/ready)
//   busy                job in progress, dropped in the done cycle
//   done                one-cycle completion pulse
//   lines_written       lines acknowledged in the current/most recent job
//
// Optional build macro RANK_WB_BRESP_CHECK_EN adds err (sticky until the next
// start) and err_count (saturating count of non-OKAY write responses).

module rank_write_packer #(
    parameter int          INT_W  = 64,
    parameter int          LINE_W = 512,
    parameter logic [15:0] AXI_ID = 16'd2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [63:0]           base_addr,
    input  logic [63:0]           n_words,
    input  logic                  in_valid,
    input  logic [INT_W-1:0]      in_data,
    output logic                  in_ready,
    output logic [15:0]           awid_m,
    output logic [63:0]           awaddr_m,
    output logic [7:0]            awlen_m,
    output logic [2:0]            awsize_m,
    output logic                  awvalid_m,
    input  logic                  awready_m,
    output logic [15:0]           wid_m,
    output logic [LINE_W-1:0]     wdata_m,
    output logic [LINE_W/8-1:0]   wstrb_m,
    output logic                  wlast_m,
    output logic                  wvalid_m,
    input  logic                  wready_m,
    input  logic [15:0]           bid_m,
    input  logic [1:0]            bresp_m,
    input  logic                  bvalid_m,
    output logic                  bready_m,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           lines_written
`ifdef RANK_WB_BRESP_CHECK_EN
    ,
    output logic                  err,
    output logic [15:0]           err_count
`endif
);

    localparam int LANES  = LINE_W / INT_W;
    localparam int CNT_W  = $clog2(LANES + 1);
    localparam int LANE_B = INT_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_RESP,
        S_FIN
    } state_t;

    state_t              state, state_nx;
    logic [63:0]         line_addr;
    logic [63:0]         remaining;
    logic [CNT_W-1:0]    lane_cnt;
    logic [LINE_W-1:0]   line_buf;
    logic                aw_done, w_done;
    logic                aw_hs, w_hs, b_hs;
    logic                line_last_word;
    logic                both_done;

    // Bits that are deliberately not used: the low address bits are forced
    // to zero (64-byte lines), and bresp only matters when error checking is
    // built in.
    logic unused_bits;
    assign unused_bits = ^{base_addr[5:0], bresp_m};

    assign aw_hs          = awvalid_m & awready_m;
    assign w_hs           = wvalid_m & wready_m;
    assign b_hs           = bvalid_m & bready_m;
    // The transfer that fills the last lane, or that delivers the final word
    // of the job, closes the current line.
    assign line_last_word = (lane_cnt == CNT_W'(LANES - 1)) || (remaining == 64'd1);
    // AW and W may complete in different cycles. A handshake in this cycle
    // counts the same as one already recorded.
    assign both_done      = (aw_done | aw_hs) & (w_done | w_hs);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (n_words == 64'd0) ? S_FIN : S_FILL;
                end
            end
            S_FILL: begin
                if (in_valid && line_last_word) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (both_done) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (b_hs) begin
                    state_nx = (remaining != 64'd0) ? S_FILL : S_FIN;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs. bready only accepts responses that carry our own ID.
    always_comb begin
        in_ready  = (state == S_FILL);
        awvalid_m = (state == S_ISSUE) && !aw_done;
        wvalid_m  = (state == S_ISSUE) && !w_done;
        wlast_m   = wvalid_m;
        bready_m  = (state == S_RESP) && (bid_m == AXI_ID);
        busy      = (state == S_FILL) || (state == S_ISSUE) || (state == S_RESP);
        done      = (state == S_FIN);
        awid_m    = AXI_ID;
        wid_m     = AXI_ID;
        awlen_m   = 8'd0;
        awsize_m  = 3'b110;
        awaddr_m  = line_addr;
        wdata_m   = line_buf;
    end

    // Byte strobes cover exactly the lanes filled so far. The buffer is cleared
    // between lines, so unused lanes also carry zero data.
    always_comb begin
        wstrb_m = '0;
        for (int j = 0; j < LANES; j++) begin
            if (CNT_W'(j) < lane_cnt) begin
                wstrb_m[j*LANE_B +: LANE_B] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_addr     <= '0;
            remaining     <= '0;
            lane_cnt      <= '0;
            line_buf      <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            lines_written <= '0;
`ifdef RANK_WB_BRESP_CHECK_EN
            err           <= 1'b0;
            err_count     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        line_addr     <= {base_addr[63:6], 6'b0};
                        remaining     <= n_words;
                        lines_written <= '0;
                        lane_cnt      <= '0;
                        line_buf      <= '0;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
`ifdef RANK_WB_BRESP_CHECK_EN
                        err           <= 1'b0;
`endif
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        for (int j = 0; j < LANES; j++) begin
                            if (lane_cnt == CNT_W'(j)) begin
                                line_buf[j*INT_W +: INT_W] <= in_data;
                            end
                        end
                        lane_cnt  <= lane_cnt + CNT_W'(1);
                        remaining <= remaining - 64'd1;
                    end
                end
                S_ISSUE: begin
                    if (both_done) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done | aw_hs;
                        w_done  <= w_done | w_hs;
                    end
                end
                S_RESP: begin
                    if (b_hs) begin
                        lines_written <= lines_written + 64'd1;
                        line_addr     <= line_addr + 64'd64;
                        lane_cnt      <= '0;
                        line_buf      <= '0;
`ifdef RANK_WB_BRESP_CHECK_EN
                        if (bresp_m != 2'b00) begin
                            err <= 1'b1;
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rank_write_packer.sv
// Testbench for rank_write_packer. The reference model tracks a job as
// counts of accepted words, AW/W handshakes and B responses. From those
// counts it derives every handshake output, the expected line contents and
// the expected completion on each cycle.
module tb_rank_write_packer;

    localparam int          INT_W  = 64;
    localparam int          LINE_W = 512;
    localparam logic [15:0] AXI_ID = 16'd2;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [63:0]         base_addr, n_words;
    logic                in_valid;
    logic [INT_W-1:0]    in_data;
    logic                in_ready;
    logic [15:0]         awid_m;
    logic [63:0]         awaddr_m;
    logic [7:0]          awlen_m;
    logic [2:0]          awsize_m;
    logic                awvalid_m, awready_m;
    logic [15:0]         wid_m;
    logic [LINE_W-1:0]   wdata_m;
    logic [LINE_W/8-1:0] wstrb_m;
    logic                wlast_m, wvalid_m, wready_m;
    logic [15:0]         bid_m;
    logic [1:0]          bresp_m;
    logic                bvalid_m, bready_m;
    logic                busy, done;
    logic [63:0]         lines_written;
`ifdef RANK_WB_BRESP_CHECK_EN
    logic                err;
    logic [15:0]         err_count;
`endif

    rank_write_packer #(.INT_W(INT_W), .LINE_W(LINE_W), .AXI_ID(AXI_ID)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .n_words(n_words), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
        .awvalid_m(awvalid_m), .awready_m(awready_m), .wid_m(wid_m), .wdata_m(wdata_m),
        .wstrb_m(wstrb_m), .wlast_m(wlast_m), .wvalid_m(wvalid_m), .wready_m(wready_m),
        .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .busy(busy), .done(done), .lines_written(lines_written)
`ifdef RANK_WB_BRESP_CHECK_EN
        , .err(err), .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state
    bit          mon_en = 0;
    bit          job_active = 0;
    logic [63:0] m_base = '0, m_n = '0, m_lines = '0, lw_model = '0;
    int          acc = 0, awc = 0, wc = 0, bc = 0;
    int          done_count = 0;
    int          cycle = 0;
    bit          err_m = 0;
    logic [15:0] errc_m = '0;
    logic [63:0] job_words [0:255];
    logic [63:0]  aw_log[$];
    logic [511:0] wdata_log[$];
    logic [63:0]  wstrb_log[$];
    int           aw_cyc[$], w_cyc[$];
    logic [63:0] m_lim;
    bit e_line, e_fill, e_aw, e_w, e_resp, e_br, e_done, e_busy;

    // Stimulus controls
    int          mode = 0;        // 0 always ready, 1 random, 2 AW skew + wrong-ID B
    bit          cont_valid = 1;
    bit          spur_en = 0;
    bit          err_mode = 0;
    int          hold_line = -1;
    bit          start_req = 0;
    logic [63:0] req_base, req_n;
    int          aw_wait = 0, wrong_cnt = 0;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] exp_line(input int li);
        logic [511:0] r = '0;
        for (int j = 0; j < 8; j++)
            if (64'(li*8 + j) < m_n) r[j*64 +: 64] = job_words[li*8 + j];
        return r;
    endfunction

    function automatic logic [63:0] exp_strb(input int li);
        logic [63:0] r = '0;
        for (int j = 0; j < 8; j++)
            if (64'(li*8 + j) < m_n) r[j*8 +: 8] = 8'hFF;
        return r;
    endfunction

    // Compare process: derive this cycle's outputs from the job counters,
    // check them, then advance the counters by the handshakes that the next
    // rising edge will complete.
    always @(negedge clk) begin
        if (mon_en) begin
            m_lim  = (m_n < 64'(8*(bc+1))) ? m_n : 64'(8*(bc+1));
            e_line = job_active && (64'(bc) < m_lines) && (64'(acc) == m_lim);
            e_fill = job_active && (64'(bc) < m_lines) && (64'(acc) < m_lim);
            e_aw   = e_line && (awc == bc);
            e_w    = e_line && (wc == bc);
            e_resp = e_line && (awc > bc) && (wc > bc);
            e_br   = e_resp && (bid_m == AXI_ID);
            e_done = job_active && (64'(bc) == m_lines);
            e_busy = job_active && !e_done;

            checkOutput("in_ready", in_ready, e_fill);
            checkOutput("awvalid", awvalid_m, e_aw);
            checkOutput("wvalid", wvalid_m, e_w);
            checkOutput("bready", bready_m, e_br);
            checkOutput("done", done, e_done);
            checkOutput("busy", busy, e_busy);
            checkOutput("lines_written", lines_written, lw_model);
            checkOutput("ax_const", {awid_m, wid_m, awlen_m, awsize_m}, {AXI_ID, AXI_ID, 8'd0, 3'b110});
            if (wvalid_m) checkOutput("wlast", wlast_m, 1'b1);
            if (awvalid_m) checkOutput("awaddr", awaddr_m, m_base + 64'(bc) * 64);
            if (wvalid_m) begin
                checkOutput("wdata", wdata_m, exp_line(bc));
                checkOutput("wstrb", wstrb_m, exp_strb(bc));
            end
`ifdef RANK_WB_BRESP_CHECK_EN
            checkOutput("err", err, err_m);
            checkOutput("err_count", err_count, errc_m);
`endif
            if (!reset_n) begin
                job_active = 0; acc = 0; awc = 0; wc = 0; bc = 0;
                lw_model = '0; err_m = 0; errc_m = '0;
            end else if (job_active) begin
                if (e_fill && in_valid) acc++;
                if (e_aw && awready_m) begin
                    awc++; aw_log.push_back(awaddr_m); aw_cyc.push_back(cycle);
                end
                if (e_w && wready_m) begin
                    wc++; wdata_log.push_back(wdata_m); wstrb_log.push_back(wstrb_m); w_cyc.push_back(cycle);
                end
                if (e_br && bvalid_m) begin
                    bc++; lw_model++;
                    if (bresp_m != 2'b00) begin
                        err_m = 1;
                        if (errc_m != 16'hFFFF) errc_m++;
                    end
                end
                if (e_done) begin
                    job_active = 0; done_count++;
                end
            end else if (start) begin
                job_active = 1;
                m_base = base_addr & ~64'd63;
                m_n = n_words;
                m_lines = (n_words + 64'd7) / 64'd8;
                acc = 0; awc = 0; wc = 0; bc = 0;
                lw_model = '0; err_m = 0;
            end
        end
        cycle++;
    end

    // One clock of stimulus: drive every input just after the rising edge.
    task automatic tick();
        bit outstanding;
        @(posedge clk);
        #1;
        start = 0;
        if (start_req) begin
            start = 1; base_addr = req_base; n_words = req_n; start_req = 0;
        end else begin
            base_addr = {$urandom, $urandom};
            n_words   = {$urandom, $urandom};
            if (spur_en && job_active && $urandom_range(0, 15) == 0) start = 1;
        end
        in_valid = job_active && (64'(acc) < m_n) && (cont_valid || $urandom_range(0, 3) != 0);
        in_data  = (64'(acc) < m_n) ? job_words[acc] : {$urandom, $urandom};
        aw_wait  = awvalid_m ? aw_wait + 1 : 0;
        case (mode)
            1:       begin awready_m = 1'($urandom_range(0, 1)); wready_m = 1'($urandom_range(0, 1)); end
            2:       begin awready_m = (aw_wait > 5); wready_m = 1'b1; end
            default: begin awready_m = 1'b1; wready_m = 1'b1; end
        endcase
        outstanding = job_active && (awc > bc) && (wc > bc) && (bc != hold_line);
        bresp_m = (err_mode && bc == 0) ? 2'b10 : 2'b00;
        if (outstanding) begin
            if (mode == 2 && wrong_cnt < 3) begin
                bvalid_m = 1'b1; bid_m = 16'd7; wrong_cnt++;
            end else begin
                bid_m = AXI_ID;
                bvalid_m = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end else begin
            bvalid_m = 1'b0;
            bid_m = 16'($urandom_range(0, 3));
            wrong_cnt = 0;
        end
    endtask

    task automatic startJob(input logic [63:0] base, input int n, input bit seq_words);
        for (int i = 0; i < 256; i++)
            job_words[i] = seq_words ? 64'(i + 1) : {$urandom, $urandom};
        aw_log.delete(); wdata_log.delete(); wstrb_log.delete();
        aw_cyc.delete(); w_cyc.delete();
        req_base = base; req_n = 64'(n); start_req = 1;
        tick();
    endtask

    task automatic waitDone();
        int dc0 = done_count;
        int k = 0;
        while (done_count == dc0 && k < 4000) begin
            tick(); k++;
        end
        checkOutput("job_done_in_time", done_count != dc0, 1'b1);
        tick();
    endtask

    task automatic applyStimulus(input logic [63:0] base, input int n, input bit seq_words);
        startJob(base, n, seq_words);
        waitDone();
    endtask

    initial begin
        reset_n = 0; start = 0; base_addr = '0; n_words = '0;
        in_valid = 0; in_data = '0; awready_m = 0; wready_m = 0;
        bid_m = '0; bresp_m = '0; bvalid_m = 0;
        repeat (3) tick();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_valids", {in_ready, awvalid_m, wvalid_m, bready_m}, 4'b0);
        checkOutput("rst_lines", lines_written, 64'd0);
        mon_en = 1;
        reset_n = 1;
        tick();

        // Full lines
        mode = 0; cont_valid = 1;
        applyStimulus(64'h1000, 16, 1);
        checkOutput("full_aw_count", aw_log.size(), 2);
        if (aw_log.size() == 2) begin
            checkOutput("full_addr0", aw_log[0], 64'h1000);
            checkOutput("full_addr1", aw_log[1], 64'h1040);
        end
        if (wdata_log.size() > 0) begin
            checkOutput("full_data0", wdata_log[0], {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
            checkOutput("full_strb0", wstrb_log[0], 64'hFFFF_FFFF_FFFF_FFFF);
        end
        checkOutput("full_lines", lines_written, 64'd2);

        // Partial tail
        applyStimulus(64'h2000, 11, 1);
        if (wdata_log.size() == 2) begin
            checkOutput("tail_addr1", aw_log[1], 64'h2040);
            checkOutput("tail_data1", wdata_log[1], {320'd0, 64'd11, 64'd10, 64'd9});
            checkOutput("tail_strb1", wstrb_log[1], 64'h0000_0000_00FF_FFFF);
        end else checkOutput("tail_w_count", wdata_log.size(), 2);
        checkOutput("tail_lines", lines_written, 64'd2);

        // Zero-length job
        applyStimulus(64'h2400, 0, 1);
        checkOutput("zero_aw", aw_log.size() + wdata_log.size(), 0);
        checkOutput("zero_lines", lines_written, 64'd0);

        // AW backpressure skew with a foreign-ID response first
        mode = 2;
        applyStimulus(64'h3000, 8, 1);
        if (aw_cyc.size() == 1 && w_cyc.size() == 1)
            checkOutput("skew_w_first", w_cyc[0] < aw_cyc[0], 1'b1);
        else checkOutput("skew_hs_count", aw_cyc.size() + w_cyc.size(), 2);
        checkOutput("skew_lines", lines_written, 64'd1);

        // Reset while waiting for the response of line 1
        mode = 0; hold_line = 1;
        startJob(64'h4000, 16, 0);
        for (int k = 0; k < 500 && !(bc == 1 && awc == 2 && wc == 2); k++) tick();
        checkOutput("reach_resp1", (bc == 1 && awc == 2 && wc == 2), 1'b1);
        reset_n = 0;
        tick();
        reset_n = 1;
        hold_line = -1;
        checkOutput("midrst_outs", {in_ready, awvalid_m, wvalid_m, bready_m, busy, done}, 6'b0);
        checkOutput("midrst_lines", lines_written, 64'd0);
        tick();
        applyStimulus(64'h5000, 8, 0);
        checkOutput("post_rst_addr", aw_log.size() == 1 && aw_log[0] == 64'h5000, 1'b1);
        checkOutput("post_rst_lines", lines_written, 64'd1);

        // Randomized jobs with random handshakes and ignored starts while busy
        spur_en = 1;
        for (int j = 0; j < 12; j++) begin
            mode = (j % 4 == 3) ? 2 : 1;
            cont_valid = 1'($urandom_range(0, 1));
            applyStimulus({$urandom, $urandom}, $urandom_range(1, 60), 0);
        end
        spur_en = 0;

`ifdef RANK_WB_BRESP_CHECK_EN
        mode = 0; cont_valid = 1; err_mode = 1;
        applyStimulus(64'h6000, 24, 1);
        err_mode = 0;
        checkOutput("err_flag", err, 1'b1);
        checkOutput("err_cnt", err_count, 16'd1);
        checkOutput("err_lines", lines_written, 64'd3);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
